// File: rtl/brq_hpm_pkg.sv
// brq_hpm_pkg: shared definitions for the hardware performance-monitor
// counter bank.
//   HpmMaxCounters - upper bound on counters a bank may implement
//   HpmEvSelNone   - event-select encoding that never counts
//   brq_hpm_wr_t   - bundled counter write request for CSR-unit hookup
//   hpm_idx_w()    - index width for a bank, never less than one bit
package brq_hpm_pkg;

  localparam int unsigned HpmMaxCounters = 29;
  localparam int unsigned HpmIdxMaxW     = 5;
  localparam int unsigned HpmEvSelNone   = 0;

  typedef struct packed {
    logic                  we;
    logic                  hi;
    logic [HpmIdxMaxW-1:0] idx;
    logic [31:0]           wdata;
  } brq_hpm_wr_t;

  // $clog2(1) is 0, which would give a zero-width index port.
  function automatic int unsigned hpm_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/brq_hpm_cnt_slice.sv
// brq_hpm_cnt_slice: one performance counter with its event-select
// register, increment logic, 32-bit half-word load and overflow flag.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   event_i         event vector shared by all slices
//   inhibit_i       stop counting while high
//   cnt_we_i        write strobe, already decoded for this slice
//   cnt_hi_i        0: load bits [31:0], 1: load bits [63:32]
//   cnt_wdata_i     write data
//   sel_we_i        event-select write strobe, already decoded
//   sel_wdata_i     new event select
//   ovf_clr_i       clear the overflow flag
//   cnt_o, sel_o    current counter value and event select
//   ovf_o           sticky overflow flag
// Macro BRQ_HPM_OVF_IRQ_EN builds the overflow flag; otherwise ovf_o is 0.
module brq_hpm_cnt_slice
  import brq_hpm_pkg::*;
#(
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned EvSelW       = $clog2(NumEvents + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumEvents-1:0]    event_i,
  input  logic                    inhibit_i,
  input  logic                    cnt_we_i,
  input  logic                    cnt_hi_i,
  input  logic [31:0]             cnt_wdata_i,
  input  logic                    sel_we_i,
  input  logic [EvSelW-1:0]       sel_wdata_i,
  input  logic                    ovf_clr_i,
  output logic [CounterWidth-1:0] cnt_o,
  output logic [EvSelW-1:0]       sel_o,
  output logic                    ovf_o
);

  logic [EvSelW-1:0]       sel_q;
  logic [CounterWidth-1:0] cnt_q;
  logic [CounterWidth-1:0] cnt_wr;
  logic [63:0]             cnt_ext;
  logic [63:0]             wr_ext;
  logic                    ev_hit;
  logic                    inc;

  // Select k counts event_i[k-1]; 0 and anything above NumEvents match no
  // event. The loop avoids a variable index that could run off the vector.
  // NOTE: ev_hit is defaulted before the loop so every path assigns it and
  // no latch is inferred.
  always_comb begin
    ev_hit = 1'b0;
    if (sel_q != EvSelW'(HpmEvSelNone)) begin
      for (int k = 0; k < NumEvents; k++) begin
        if (sel_q == EvSelW'(k + 1)) ev_hit = event_i[k];
      end
    end
  end

  assign inc = ev_hit & ~inhibit_i;

  // Work on a 64-bit view so both halves have fixed positions, then keep
  // only the implemented bits; data above CounterWidth falls away here.
  assign cnt_ext = 64'(cnt_q);
  assign wr_ext  = cnt_hi_i ? {cnt_wdata_i, cnt_ext[31:0]}
                            : {cnt_ext[63:32], cnt_wdata_i};
  assign cnt_wr  = wr_ext[CounterWidth-1:0];

  logic unused_ext;
  assign unused_ext = ^{cnt_ext, wr_ext};

  // NOTE: state is reset asynchronously on rst_ni low, independent of clk_i.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      // A write takes priority; a same-cycle increment is dropped.
      if (cnt_we_i)  cnt_q <= cnt_wr;
      else if (inc)  cnt_q <= cnt_q + CounterWidth'(1);
      if (sel_we_i)  sel_q <= sel_wdata_i;
    end
  end

`ifdef BRQ_HPM_OVF_IRQ_EN
  logic ovf_q;
  logic ovf_set;

  // Only a real increment from all-ones wraps; a write never does.
  assign ovf_set = inc & ~cnt_we_i & (&cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        ovf_q <= 1'b0;
    else if (ovf_set)   ovf_q <= 1'b1;
    else if (ovf_clr_i) ovf_q <= 1'b0;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr_i;
  assign ovf_o          = 1'b0;
`endif

  assign cnt_o = cnt_q;
  assign sel_o = sel_q;

endmodule

// File: rtl/brq_hpm_counter_bank.sv
// brq_hpm_counter_bank: bank of NumCounters performance-monitor counters
// with half-word CSR writes, per-counter event select and inhibit, sticky
// overflow flags and one registered read port.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   event_i                   per-cycle event pulses
//   inhibit_i                 per-counter count inhibit
//   cnt_we_i/cnt_hi_i         counter write strobe and half select
//   cnt_idx_i/cnt_wdata_i     written counter and data
//   sel_we_i/sel_wdata_i      event-select write (addressed by cnt_idx_i)
//   ovf_clr_i                 per-counter overflow clear
//   rd_idx_i                  counter to read
//   rd_val_o/rd_sel_o         registered read value and event select
//   ovf_o                     sticky overflow flags
//   irq_o                     registered OR of ovf_o
// Macro BRQ_HPM_OVF_IRQ_EN builds the overflow flags and interrupt;
// without it ovf_o and irq_o are tied to 0.
module brq_hpm_counter_bank
  import brq_hpm_pkg::*;
#(
  parameter  int unsigned NumCounters  = 4,
  parameter  int unsigned CounterWidth = 40,
  parameter  int unsigned NumEvents    = 16,
  localparam int unsigned EvSelW       = $clog2(NumEvents + 1),
  localparam int unsigned IdxW         = hpm_idx_w(NumCounters)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   event_i,
  input  logic [NumCounters-1:0] inhibit_i,
  input  logic                   cnt_we_i,
  input  logic                   cnt_hi_i,
  input  logic [IdxW-1:0]        cnt_idx_i,
  input  logic [31:0]            cnt_wdata_i,
  input  logic                   sel_we_i,
  input  logic [EvSelW-1:0]      sel_wdata_i,
  input  logic [NumCounters-1:0] ovf_clr_i,
  input  logic [IdxW-1:0]        rd_idx_i,
  output logic [63:0]            rd_val_o,
  output logic [EvSelW-1:0]      rd_sel_o,
  output logic [NumCounters-1:0] ovf_o,
  output logic                   irq_o
);

  logic [CounterWidth-1:0] cnt [NumCounters];
  logic [EvSelW-1:0]       sel [NumCounters];
  logic [NumCounters-1:0]  ovf;

  // An index matching no slice decodes to no strobe, so out-of-range
  // writes are dropped without a separate range check.
  for (genvar i = 0; i < NumCounters; i++) begin : g_slice
    logic hit;
    assign hit = (cnt_idx_i == IdxW'(i));

    brq_hpm_cnt_slice #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents),
      .EvSelW       (EvSelW)
    ) u_slice (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .event_i     (event_i),
      .inhibit_i   (inhibit_i[i]),
      .cnt_we_i    (cnt_we_i & hit),
      .cnt_hi_i    (cnt_hi_i),
      .cnt_wdata_i (cnt_wdata_i),
      .sel_we_i    (sel_we_i & hit),
      .sel_wdata_i (sel_wdata_i),
      .ovf_clr_i   (ovf_clr_i[i]),
      .cnt_o       (cnt[i]),
      .sel_o       (sel[i]),
      .ovf_o       (ovf[i])
    );
  end

  logic [63:0]       rd_val_d;
  logic [EvSelW-1:0] rd_sel_d;

  // Out-of-range read index leaves the zero defaults in place.
  always_comb begin
    rd_val_d = '0;
    rd_sel_d = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (rd_idx_i == IdxW'(i)) begin
        rd_val_d = 64'(cnt[i]);
        rd_sel_d = sel[i];
      end
    end
  end

  // Registered from pre-edge state: a write lands one edge later and is
  // captured here on the following edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_val_o <= '0;
      rd_sel_o <= '0;
    end else begin
      rd_val_o <= rd_val_d;
      rd_sel_o <= rd_sel_d;
    end
  end

  assign ovf_o = ovf;

`ifdef BRQ_HPM_OVF_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= |ovf;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_brq_hpm_counter_bank.sv
// Self-checking bench for brq_hpm_counter_bank. Three counters are built so
// that index 3 is out of range. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_brq_hpm_counter_bank;

  localparam int unsigned NC     = 3;
  localparam int unsigned CW     = 40;
  localparam int unsigned NE     = 16;
  localparam int unsigned EvSelW = $clog2(NE + 1);
  localparam int unsigned IdxW   = 2;

`ifdef BRQ_HPM_OVF_IRQ_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic              clk_i;
  logic              rst_ni;
  logic [NE-1:0]     event_i;
  logic [NC-1:0]     inhibit_i;
  logic              cnt_we_i;
  logic              cnt_hi_i;
  logic [IdxW-1:0]   cnt_idx_i;
  logic [31:0]       cnt_wdata_i;
  logic              sel_we_i;
  logic [EvSelW-1:0] sel_wdata_i;
  logic [NC-1:0]     ovf_clr_i;
  logic [IdxW-1:0]   rd_idx_i;
  logic [63:0]       rd_val_o;
  logic [EvSelW-1:0] rd_sel_o;
  logic [NC-1:0]     ovf_o;
  logic              irq_o;

  brq_hpm_counter_bank #(
    .NumCounters  (NC),
    .CounterWidth (CW),
    .NumEvents    (NE)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .event_i     (event_i),
    .inhibit_i   (inhibit_i),
    .cnt_we_i    (cnt_we_i),
    .cnt_hi_i    (cnt_hi_i),
    .cnt_idx_i   (cnt_idx_i),
    .cnt_wdata_i (cnt_wdata_i),
    .sel_we_i    (sel_we_i),
    .sel_wdata_i (sel_wdata_i),
    .ovf_clr_i   (ovf_clr_i),
    .rd_idx_i    (rd_idx_i),
    .rd_val_o    (rd_val_o),
    .rd_sel_o    (rd_sel_o),
    .ovf_o       (ovf_o),
    .irq_o       (irq_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    string             name;
    logic              cnt_we;
    logic              cnt_hi;
    logic [IdxW-1:0]   cnt_idx;
    logic [31:0]       wdata;
    logic              sel_we;
    logic [EvSelW-1:0] sel;
    logic [NE-1:0]     ev;
    logic [NC-1:0]     inh;
    int                cycles;
    logic [IdxW-1:0]   rd_idx;
    logic [63:0]       exp_val;
    logic [EvSelW-1:0] exp_sel;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic cw, input logic hi,
                         input logic [IdxW-1:0] idx, input logic [31:0] wd,
                         input logic sw, input logic [EvSelW-1:0] sl,
                         input logic [NE-1:0] ev, input logic [NC-1:0] inh,
                         input int cyc, input logic [IdxW-1:0] ri,
                         input logic [63:0] ev_exp,
                         input logic [EvSelW-1:0] es_exp);
    vec_t v;
    v.name = name; v.cnt_we = cw; v.cnt_hi = hi; v.cnt_idx = idx;
    v.wdata = wd; v.sel_we = sw; v.sel = sl; v.ev = ev; v.inh = inh;
    v.cycles = cyc; v.rd_idx = ri; v.exp_val = ev_exp; v.exp_sel = es_exp;
    vecs.push_back(v);
  endtask

  task automatic idle();
    event_i     = '0;
    inhibit_i   = '0;
    cnt_we_i    = 1'b0;
    cnt_hi_i    = 1'b0;
    cnt_idx_i   = '0;
    cnt_wdata_i = '0;
    sel_we_i    = 1'b0;
    sel_wdata_i = '0;
    ovf_clr_i   = '0;
  endtask

  task automatic read_check(input string name, input logic [IdxW-1:0] idx,
                            input logic [63:0] exp_val,
                            input logic [EvSelW-1:0] exp_sel);
    idle();
    rd_idx_i = idx;
    @(negedge clk_i);
    check({name, ".val"}, rd_val_o, exp_val);
    check({name, ".sel"}, 64'(rd_sel_o), 64'(exp_sel));
  endtask

  task automatic write_cnt(input logic [IdxW-1:0] idx, input logic hi,
                           input logic [31:0] data);
    idle();
    cnt_we_i = 1'b1; cnt_hi_i = hi; cnt_idx_i = idx; cnt_wdata_i = data;
    @(negedge clk_i);
    idle();
  endtask

  task automatic write_sel(input logic [IdxW-1:0] idx,
                           input logic [EvSelW-1:0] s);
    idle();
    sel_we_i = 1'b1; cnt_idx_i = idx; sel_wdata_i = s;
    @(negedge clk_i);
    idle();
  endtask

  initial begin
    //        name        we hi idx wdata         swe sel ev        inh  cyc rd exp_val          exp_sel
    add_vec("sel3_c0",    0, 0, 0, 32'h0,        1, 3,  16'h0000, 3'b000, 1, 0, 64'h0,            5'd3);
    add_vec("count10",    0, 0, 0, 32'h0,        0, 0,  16'h0004, 3'b000,10, 0, 64'd10,           5'd3);
    add_vec("c1_idle",    0, 0, 0, 32'h0,        0, 0,  16'h0000, 3'b000, 0, 1, 64'h0,            5'd0);
    add_vec("c2_idle",    0, 0, 0, 32'h0,        0, 0,  16'h0000, 3'b000, 0, 2, 64'h0,            5'd0);
    add_vec("inhibit",    0, 0, 0, 32'h0,        0, 0,  16'h0004, 3'b001, 5, 0, 64'd10,           5'd3);
    add_vec("sel_none",   0, 0, 2, 32'h0,        1, 0,  16'hFFFF, 3'b001, 3, 2, 64'h0,            5'd0);
    add_vec("sel_17",     0, 0, 2, 32'h0,        1, 17, 16'hFFFF, 3'b001, 4, 2, 64'h0,            5'd17);
    add_vec("sel_31",     0, 0, 2, 32'h0,        1, 31, 16'hFFFF, 3'b001, 2, 2, 64'h0,            5'd31);
    add_vec("sel1_c2",    0, 0, 2, 32'h0,        1, 1,  16'h0000, 3'b000, 1, 2, 64'h0,            5'd1);
    add_vec("wr_vs_inc",  1, 0, 2, 32'h55,       0, 0,  16'h0001, 3'b000, 1, 2, 64'h55,           5'd1);
    add_vec("inc_after",  0, 0, 0, 32'h0,        0, 0,  16'h0001, 3'b000, 1, 2, 64'h56,           5'd1);
    add_vec("hi_trunc",   1, 1, 2, 32'hFFFFFF12, 0, 0,  16'h0000, 3'b000, 1, 2, 64'h12_0000_0056, 5'd1);
    add_vec("lo_keep_hi", 1, 0, 2, 32'hDEADBEEF, 0, 0,  16'h0000, 3'b000, 1, 2, 64'h12_DEAD_BEEF, 5'd1);
    add_vec("oor_write",  1, 0, 3, 32'h1234,     0, 0,  16'h0000, 3'b000, 1, 3, 64'h0,            5'd0);
    add_vec("oor_nohit",  0, 0, 0, 32'h0,        0, 0,  16'h0000, 3'b000, 0, 2, 64'h12_DEAD_BEEF, 5'd1);
    add_vec("oor_sel",    0, 0, 3, 32'h0,        1, 5,  16'h0000, 3'b000, 1, 3, 64'h0,            5'd0);
    add_vec("c0_final",   0, 0, 0, 32'h0,        0, 0,  16'h0000, 3'b000, 0, 0, 64'd10,           5'd3);

    // Reset state.
    rst_ni = 1'b0;
    idle();
    rd_idx_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst.rd_val", rd_val_o, 64'h0);
    check("rst.rd_sel", 64'(rd_sel_o), 64'h0);
    check("rst.ovf", 64'(ovf_o), 64'h0);
    check("rst.irq", 64'(irq_o), 64'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) begin
      event_i     = vecs[i].ev;
      inhibit_i   = vecs[i].inh;
      cnt_we_i    = vecs[i].cnt_we;
      cnt_hi_i    = vecs[i].cnt_hi;
      cnt_idx_i   = vecs[i].cnt_idx;
      cnt_wdata_i = vecs[i].wdata;
      sel_we_i    = vecs[i].sel_we;
      sel_wdata_i = vecs[i].sel;
      repeat (vecs[i].cycles) @(negedge clk_i);
      read_check(vecs[i].name, vecs[i].rd_idx, vecs[i].exp_val, vecs[i].exp_sel);
    end

    // First wrap on counter 1 (select 4 -> event_i[3]).
    write_sel(1, 4);
    write_cnt(1, 1'b0, 32'hFFFF_FFFF);
    write_cnt(1, 1'b1, 32'h0000_00FF);
    check("wr_no_ovf", 64'(ovf_o), 64'h0);
    event_i = 16'h0008;
    @(negedge clk_i);
    idle();
    check("wrap.ovf", 64'(ovf_o), 64'({1'b0, OvfEn, 1'b0}));
    check("wrap.irq_early", 64'(irq_o), 64'h0);
    @(negedge clk_i);
    check("wrap.irq", 64'(irq_o), 64'(OvfEn));
    read_check("wrap", 1, 64'h0, 5'd4);

    // Second wrap with a simultaneous clear: the set must win.
    write_cnt(1, 1'b0, 32'hFFFF_FFFF);
    write_cnt(1, 1'b1, 32'h0000_00FF);
    event_i   = 16'h0008;
    ovf_clr_i = 3'b010;
    @(negedge clk_i);
    idle();
    check("set_vs_clr.ovf", 64'(ovf_o), 64'({1'b0, OvfEn, 1'b0}));
    ovf_clr_i = 3'b010;
    @(negedge clk_i);
    idle();
    check("clr.ovf", 64'(ovf_o), 64'h0);
    check("clr.irq_lag", 64'(irq_o), 64'(OvfEn));
    @(negedge clk_i);
    check("clr.irq", 64'(irq_o), 64'h0);
    read_check("wrap2", 1, 64'h0, 5'd4);

    // Reset mid-count with the flag set.
    write_cnt(1, 1'b0, 32'hFFFF_FFFF);
    write_cnt(1, 1'b1, 32'h0000_00FF);
    event_i = 16'h000C;
    @(negedge clk_i);
    read_check("pre_rst.c0", 0, 64'd11, 5'd3);
    check("pre_rst.irq", 64'(irq_o), 64'(OvfEn));
    event_i = 16'h0004;
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst.rd_val", rd_val_o, 64'h0);
    check("mid_rst.rd_sel", 64'(rd_sel_o), 64'h0);
    check("mid_rst.ovf", 64'(ovf_o), 64'h0);
    check("mid_rst.irq", 64'(irq_o), 64'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    read_check("post_rst.c0", 0, 64'h0, 5'd0);
    read_check("post_rst.c1", 1, 64'h0, 5'd0);
    read_check("post_rst.c2", 2, 64'h0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
